// File: rtl/alu_pkg.sv
// alu_pkg: shared op/state enums and instruction field layout
// for the ALU issue controller.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int INSTR_W = 10;
    localparam int MODE_B  = 9;
    localparam int OP_HI   = 8;
    localparam int OP_LO   = 7;
    localparam int RD_HI   = 6;
    localparam int RD_LO   = 5;
    localparam int RS1_HI  = 4;
    localparam int RS1_LO  = 3;
    localparam int RS2_HI  = 2;
    localparam int RS2_LO  = 1;
    localparam int IMM_HI  = 3;
    localparam int IMM_LO  = 0;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, executor and result signals
// between the issue controller (slave) and its environment (master).
interface alu_issue_ctrl_if
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic               INSTR_VALID;
    logic               INSTR_READY;
    logic [INSTR_W-1:0] INSTR;
    logic [3:0]         A;
    logic [3:0]         B;
    logic [1:0]         ALU_CONT;
    logic [3:0]         ALU_OUT;
    logic               RES_VALID;
    logic               RES_READY;
    logic [3:0]         RES_DATA;
    logic [1:0]         RES_RD;
    logic [CNT_W-1:0]   ISSUE_CNT;

    modport master (
        output INSTR_VALID, INSTR, ALU_OUT, RES_READY,
        input  INSTR_READY, A, B, ALU_CONT,
        input  RES_VALID, RES_DATA, RES_RD, ISSUE_CNT
    );

    modport slave (
        input  INSTR_VALID, INSTR, ALU_OUT, RES_READY,
        output INSTR_READY, A, B, ALU_CONT,
        output RES_VALID, RES_DATA, RES_RD, ISSUE_CNT
    );

endinterface

// File: rtl/regfile_4x4.sv
// regfile_4x4: four 4-bit registers, two async read ports,
// one sync write port, sync clear with priority over write.
module regfile_4x4 (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_we,
    input  logic [1:0] i_waddr,
    input  logic [3:0] i_wdata,
    input  logic [1:0] i_raddr0,
    input  logic [1:0] i_raddr1,
    output logic [3:0] o_rdata0,
    output logic [3:0] o_rdata1
);
    logic [3:0] r_mem [4];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts ALU/LDI instructions, drives an external
// ALU executor and returns results over a valid/ready channel.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input logic CLK,
    input logic RST,
    alu_issue_ctrl_if.slave bus
);
    state_e           r_state;
    logic             r_ready;
    logic             r_res_valid;
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    logic [1:0]       r_alu;
    logic [1:0]       r_rd;
    logic [3:0]       r_res_data;
    logic [CNT_W-1:0] r_cnt;

    logic       w_hs;
    logic       w_ldi;
    logic       w_exec;
    logic       w_we;
    logic [1:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_rs1;
    logic [1:0] w_rs2;
    logic [1:0] w_waddr;
    logic [3:0] w_imm;
    logic [3:0] w_wdata;
    logic [3:0] w_rdata0;
    logic [3:0] w_rdata1;

    assign w_ldi  = bus.INSTR[MODE_B];
    assign w_op   = bus.INSTR[OP_HI:OP_LO];
    assign w_rd   = bus.INSTR[RD_HI:RD_LO];
    assign w_rs1  = bus.INSTR[RS1_HI:RS1_LO];
    assign w_rs2  = bus.INSTR[RS2_HI:RS2_LO];
    assign w_imm  = bus.INSTR[IMM_HI:IMM_LO];
    assign w_hs   = bus.INSTR_VALID & r_ready;
    assign w_exec = (r_state == ST_EXEC);

    // LDI writes at its handshake, ALU ops at the end of EXEC; never both.
    assign w_we    = w_exec | (w_hs & w_ldi);
    assign w_waddr = w_exec ? r_rd : w_rd;
    assign w_wdata = w_exec ? bus.ALU_OUT : w_imm;

    regfile_4x4 u_rf (
        .i_clk    (CLK),
        .i_clr    (RST),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr0 (w_rs1),
        .i_raddr1 (w_rs2),
        .o_rdata0 (w_rdata0),
        .o_rdata1 (w_rdata1)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_res_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_alu       <= '0;
            r_rd        <= '0;
            r_res_data  <= '0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_hs) begin
                        r_ready <= 1'b0;
                        r_rd    <= w_rd;
                        if (w_ldi) begin
                            r_res_data  <= w_imm;
                            r_res_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_a     <= w_rdata0;
                            r_b     <= w_rdata1;
                            r_alu   <= w_op;
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    r_a         <= '0;
                    r_b         <= '0;
                    r_alu       <= '0;
                    r_res_data  <= bus.ALU_OUT;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.RES_READY) begin
                        r_res_valid <= 1'b0;
                        r_ready     <= 1'b1;
                        r_cnt       <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.INSTR_READY = r_ready;
    assign bus.A           = r_a;
    assign bus.B           = r_b;
    assign bus.ALU_CONT    = r_alu;
    assign bus.RES_VALID   = r_res_valid;
    assign bus.RES_DATA    = r_res_data;
    assign bus.RES_RD      = r_rd;
    assign bus.ISSUE_CNT   = r_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a 4-bit ALU executor and a
// transaction-level model checked against the DUT every cycle.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   started = 0;
    bit   prev_rst = 0;

    typedef struct {
        int data;
        int rd;
        bit alu;
        int a;
        int b;
        int op;
        int hs;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          m_reg[4];
    int          m_cnt;
    bit          m_vld;
    bit          m_exec;
    bit          m_rdy;
    logic [9:0]  m_ins;

    alu_issue_ctrl_if #(.CNT_W(8)) bus ();

    alu_issue_ctrl #(.CNT_W(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // 4-bit executor paired with the controller
    always_comb begin
        bus.ALU_OUT = 4'h0;
        case (bus.ALU_CONT)
            2'b00:   bus.ALU_OUT = bus.A + bus.B;
            2'b01:   bus.ALU_OUT = bus.A - bus.B;
            2'b10:   bus.ALU_OUT = bus.A & bus.B;
            default: bus.ALU_OUT = bus.A | bus.B;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) % 16;
            1:       return (a - b + 16) % 16;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [9:0] ldi(input int rd, input int imm);
        logic [1:0] r;
        logic [3:0] m;
        r = rd[1:0];
        m = imm[3:0];
        return {1'b1, 2'b00, r, 1'b0, m};
    endfunction

    function automatic logic [9:0] alu(input int op, input int rd,
                                       input int s1, input int s2);
        logic [1:0] o, d, a, b;
        o = op[1:0];
        d = rd[1:0];
        a = s1[1:0];
        b = s2[1:0];
        return {1'b0, o, d, a, b, 1'b0};
    endfunction

    // Model: in-flight instruction list; a result becomes visible one
    // cycle (LDI) or two cycles (ALU) after the handshake cycle.
    always @(negedge clk) begin
        cyc++;
        m_vld  = q.size() > 0 && cyc >= q[0].hs + (q[0].alu ? 2 : 1);
        m_exec = q.size() > 0 && q[0].alu && cyc == q[0].hs + 1;
        m_rdy  = q.size() == 0 && !prev_rst;
        if (started) begin
            chk("res_valid", bus.RES_VALID, m_vld);
            if (m_vld) begin
                chk("res_data", bus.RES_DATA, q[0].data);
                chk("res_rd", bus.RES_RD, q[0].rd);
            end
            chk("op_a", bus.A, m_exec ? q[0].a : 0);
            chk("op_b", bus.B, m_exec ? q[0].b : 0);
            chk("alu_cont", bus.ALU_CONT, m_exec ? q[0].op : 0);
            chk("instr_ready", bus.INSTR_READY, m_rdy);
            chk("issue_cnt", bus.ISSUE_CNT, m_cnt);
        end
        if (rst) begin
            started = 1;
            q.delete();
            for (int i = 0; i < 4; i++) m_reg[i] = 0;
            m_cnt = 0;
        end else if (started) begin
            if (m_vld && bus.RES_READY) begin
                void'(q.pop_front());
                m_cnt = (m_cnt + 1) % 256;
            end
            if (bus.INSTR_VALID && m_rdy) begin
                m_ins = bus.INSTR;
                e.hs  = cyc;
                e.rd  = int'(m_ins[6:5]);
                e.alu = !m_ins[9];
                e.op  = int'(m_ins[8:7]);
                e.a   = m_reg[m_ins[4:3]];
                e.b   = m_reg[m_ins[2:1]];
                e.data = m_ins[9] ? int'(m_ins[3:0]) : ref_alu(e.op, e.a, e.b);
                m_reg[e.rd] = e.data;
                q.push_back(e);
            end
        end
        prev_rst = rst;
    end

    task automatic send(input logic [9:0] ins);
        bit ok;
        ok = 0;
        bus.INSTR = ins;
        bus.INSTR_VALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.INSTR_READY;
            @(posedge clk);
            #2;
        end
        bus.INSTR_VALID = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_res(output int data, output int rd, output int lat);
        data = -1;
        rd = -1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.RES_VALID) begin
                lat = i;
                data = int'(bus.RES_DATA);
                rd = int'(bus.RES_RD);
                break;
            end
        end
        if (lat == 0) chk("res_timeout", 0, 1);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input string nm, input logic [9:0] ins,
                       input int ed, input int erd, input int elat);
        int d, r, l;
        send(ins);
        wait_res(d, r, l);
        chk({nm, "_data"}, d, ed);
        chk({nm, "_rd"}, r, erd);
        chk({nm, "_lat"}, l, elat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.INSTR_VALID = 1'b0;
        bus.INSTR = '0;
        bus.RES_READY = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        @(negedge clk);
        chk("rst_valid", bus.RES_VALID, 0);
        chk("rst_ready", bus.INSTR_READY, 0);
        chk("rst_cnt", bus.ISSUE_CNT, 0);
        chk("rst_a", bus.A, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_rst_cycle", bus.INSTR_READY, 0);
        @(negedge clk);
        chk("ready_after_rst", bus.INSTR_READY, 1);
        @(posedge clk);
        #2;

        run("ldi_r0", ldi(0, 5), 5, 0, 1);
        run("ldi_r1", ldi(1, 3), 3, 1, 1);
        run("add", alu(OP_ADD, 2, 0, 1), 8, 2, 2);
        run("sub_wrap", alu(OP_SUB, 3, 1, 0), 14, 3, 2);
        run("and", alu(OP_AND, 2, 0, 1), 1, 2, 2);
        run("or", alu(OP_OR, 3, 0, 1), 7, 3, 2);
        @(negedge clk);
        chk("cnt_six", bus.ISSUE_CNT, 6);
        @(posedge clk);
        #2;

        // result held under backpressure while a new offer is ignored
        bus.RES_READY = 1'b0;
        send(alu(OP_ADD, 2, 0, 1));
        @(posedge clk);
        #2;
        bus.INSTR = ldi(3, 15);
        bus.INSTR_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.RES_VALID, 1);
            chk("bp_data", bus.RES_DATA, 8);
            chk("bp_ready", bus.INSTR_READY, 0);
            @(posedge clk);
            #2;
        end
        bus.INSTR_VALID = 1'b0;
        bus.RES_READY = 1'b1;
        @(posedge clk);
        #2;
        run("r3_kept", alu(OP_OR, 3, 3, 3), 7, 3, 2);

        // reset while ADD is in EXEC
        send(alu(OP_ADD, 2, 0, 1));
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_exec_valid", bus.RES_VALID, 0);
            chk("rst_exec_cnt", bus.ISSUE_CNT, 0);
        end
        @(posedge clk);
        #2;
        run("r2_cleared", alu(OP_OR, 1, 2, 2), 0, 1, 2);

        // counter wrap after 256 completions
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                @(negedge clk);
                chk("cnt_255", bus.ISSUE_CNT, 255);
                @(posedge clk);
                #2;
                run("ldi_last", ldi(0, 6), 6, 0, 1);
            end else begin
                run("ldi_loop", ldi(i % 4, i % 16), i % 16, i % 4, 1);
            end
        end
        @(negedge clk);
        chk("cnt_wrap", bus.ISSUE_CNT, 0);
        @(posedge clk);
        #2;
        run("add_self", alu(OP_ADD, 0, 0, 0), 12, 0, 2);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of issued-instruction counter.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port INSTR_VALID  input  1  instruction offered.
REQ-005 SHALL have port INSTR_READY  output  1  controller can accept instruction.
REQ-006 SHALL have port INSTR  input  10  [9] MODE (0=ALU, 1=LDI), [8:7] OP, [6:5] RD, [4:3] RS1, [2:1] RS2; LDI uses [3:0] as IMM.
REQ-007 SHALL have port A  output  4  operand A to ALU executor.
REQ-008 SHALL have port B  output  4  operand B to ALU executor.
REQ-009 SHALL have port ALU_CONT  output  2  op select to executor (00 add, 01 sub, 10 and, 11 or).
REQ-010 SHALL have port ALU_OUT  input  4  combinational result from executor.
REQ-011 SHALL have port RES_VALID  output  1  result available.
REQ-012 SHALL have port RES_READY  input  1  consumer accepts result.
REQ-013 SHALL have port RES_DATA  output  4  result value.
REQ-014 SHALL have port RES_RD  output  2  destination register of result.
REQ-015 SHALL have port ISSUE_CNT  output  CNT_W  count of completed instructions.

Function
REQ-016 SHALL hold a 4-entry x 4-bit register file R0..R3.
REQ-017 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-018 SHALL assert INSTR_READY only in IDLE; handshake = INSTR_VALID & INSTR_READY on a clock edge.
REQ-019 SHALL on ALU-mode handshake latch OP/RD/RS1/RS2 and go IDLE->EXEC.
REQ-020 SHALL in EXEC drive A=R[RS1], B=R[RS2], ALU_CONT=OP; at end of EXEC capture ALU_OUT into RES_DATA and R[RD]; go EXEC->RESP.
REQ-021 SHALL on LDI handshake write IMM to R[RD] and RES_DATA, go IDLE->RESP directly (no ALU cycle).
REQ-022 SHALL drive A, B, ALU_CONT to 0 in all states except EXEC.
REQ-023 SHALL assert RES_VALID only in RESP with RES_DATA/RES_RD stable until RES_READY sampled high; then RESP->IDLE.
REQ-024 SHALL latency: ALU instr handshake to RES_VALID = 2 cycles; LDI = 1 cycle; min issue interval 3 (ALU) / 2 (LDI) cycles with RES_READY tied high.
REQ-025 SHALL ignore INSTR_VALID and INSTR outside IDLE.
REQ-026 SHALL allow RD equal RS1/RS2; operands read in EXEC before write.
REQ-027 SHALL treat ALU_OUT as modulo-4-bit (sub underflow wraps; no carry/borrow tracked).
REQ-028 SHALL increment ISSUE_CNT on each RESP->IDLE transition, wrapping 2^CNT_W-1 -> 0.

Reset
REQ-029 SHALL when RST high at edge: state IDLE, R0..R3=0, RES_DATA=0, RES_RD=0, RES_VALID=0, ISSUE_CNT=0, A/B/ALU_CONT=0.
REQ-030 SHALL on RST mid-EXEC or mid-RESP discard in-flight instruction with no register write and no count increment.
REQ-031 SHALL drive INSTR_READY=0 in the reset cycle, 1 the following cycle.

Structure
REQ-032 SHALL place in shared package alu_pkg: ALU op enum (ADD/SUB/AND/OR=00/01/10/11), FSM state enum, INSTR field bit positions.
REQ-033 SHALL implement register file as sub-module regfile_4x4 (two async read ports, one sync write port, sync clear).

Verification
REQ-034 SHALL bench pair with the 4-bit ALU executor: LDI R0=5, LDI R1=3, ADD R2=R0+R1 -> RES_DATA=8, RES_RD=2, 2 cycles after handshake.
REQ-035 SHALL check SUB R3=R1-R0 (3-5) -> RES_DATA=0xE (wrap); AND 5&3 -> 1; OR 5|3 -> 7.
REQ-036 SHALL hold RES_READY low 4 cycles in RESP -> RES_VALID/RES_DATA stable, INSTR_READY=0, new INSTR_VALID ignored.
REQ-037 SHALL assert RST during EXEC of ADD R2 -> R2 reads 0 afterwards, ISSUE_CNT=0, RES_VALID never asserted.
REQ-038 SHALL issue 256 LDIs with CNT_W=8 -> ISSUE_CNT wraps to 0; ADD R0=R0+R0 with R0=6 -> 0xC.
